// File: rtl/vdp1_cmd_fetch.sv
// VDP1 command-list reader: walks command tables in VRAM, follows jump modes,
// and hands each assembled, masked table to the draw engine via valid/ack.
package vdp1_cmd_fetch_pkg;
    typedef struct packed {
        logic [15:0] CMDCTRL;
        logic [15:0] CMDLINK;
        logic [15:0] CMDPMOD;
        logic [15:0] CMDCOLR;
        logic [15:0] CMDSRCA;
        logic [15:0] CMDSIZE;
        logic [15:0] CMDXA;
        logic [15:0] CMDYA;
        logic [15:0] CMDXB;
        logic [15:0] CMDYB;
        logic [15:0] CMDXC;
        logic [15:0] CMDYC;
        logic [15:0] CMDXD;
        logic [15:0] CMDYD;
        logic [15:0] CMDGRDA;
        logic [15:0] UNUSED;
    } CMDTBL_t;
endpackage

module vdp1_cmd_fetch
    import vdp1_cmd_fetch_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic [17:0] VRAM_A,
    output logic        VRAM_RD,
    input  logic [15:0] VRAM_D,
    input  logic        VRAM_RDY,
    output CMDTBL_t     CMD,
    output logic        CMD_VALID,
    input  logic        CMD_ACK,
    output logic [15:0] COPR,
    output logic [15:0] LOPR,
    output logic        CEF,
    output logic        BUSY
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_CTRL, S_RD_LINK, S_RD_BODY, S_DISPATCH, S_NEXT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] t_q, t_d;
    logic [15:0] r_q, r_d;
    logic        rpend_q, rpend_d;
    logic [15:0] lopr_q, lopr_d;
    logic        cef_q, cef_d;
    logic [15:0] words_q [15];
    logic        word_we;
    logic [15:0] word_wdata;
    logic        rd_active;
    logic        rdy_ok;
    logic [255:0] cmd_flat;

    function automatic logic [15:0] word_mask(input logic [3:0] i);
        case (i)
            4'd0:    return 16'hFF3F;
            4'd1:    return 16'hFFFC;
            4'd2:    return 16'h9FFF;
            4'd5:    return 16'h3FFF;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic comm_ok(input logic [3:0] c);
        case (c)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign rd_active  = (state_q == S_RD_CTRL) || (state_q == S_RD_LINK) || (state_q == S_RD_BODY);
    assign rdy_ok     = rd_active && VRAM_RDY;
    assign word_wdata = VRAM_D & word_mask(idx_q);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        t_d     = t_q;
        r_d     = r_q;
        rpend_d = rpend_q;
        lopr_d  = lopr_q;
        cef_d   = cef_q;
        word_we = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    t_d     = 16'h0000;
                    idx_d   = 4'd0;
                    rpend_d = 1'b0;
                    cef_d   = 1'b0;
                    state_d = S_RD_CTRL;
                end
            end
            S_RD_CTRL: begin
                if (rdy_ok) begin
                    word_we = 1'b1;
                    if (word_wdata[15] || !comm_ok(word_wdata[3:0])) begin
                        cef_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = 4'd1;
                        state_d = word_wdata[14] ? S_RD_LINK : S_RD_BODY;
                    end
                end
            end
            S_RD_LINK: begin
                if (rdy_ok) begin
                    word_we = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_RD_BODY: begin
                if (rdy_ok) begin
                    word_we = 1'b1;
                    if (idx_q == 4'd14) state_d = S_DISPATCH;
                    else                idx_d   = idx_q + 4'd1;
                end
            end
            S_DISPATCH: begin
                if (CMD_ACK) begin
                    lopr_d  = t_q;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                // A call while a return is pending degrades to assign; R is kept.
                unique case (words_q[0][13:12])
                    2'b00: t_d = t_q + 16'd4;
                    2'b01: t_d = words_q[1];
                    2'b10: begin
                        t_d = words_q[1];
                        if (!rpend_q) begin
                            r_d     = t_q + 16'd4;
                            rpend_d = 1'b1;
                        end
                    end
                    default: begin
                        if (rpend_q) begin
                            t_d     = r_q;
                            rpend_d = 1'b0;
                        end else begin
                            t_d = t_q + 16'd4;
                        end
                    end
                endcase
                idx_d   = 4'd0;
                state_d = S_RD_CTRL;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            t_q     <= 16'h0000;
            r_q     <= 16'h0000;
            rpend_q <= 1'b0;
            lopr_q  <= 16'h0000;
            cef_q   <= 1'b0;
            for (int i = 0; i < 15; i++) words_q[i] <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
            r_q     <= r_d;
            rpend_q <= rpend_d;
            lopr_q  <= lopr_d;
            cef_q   <= cef_d;
            if (word_we) words_q[idx_q] <= word_wdata;
        end
    end

    // Word 15 is never fetched, so its slot in the table stays zero.
    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_word
            assign cmd_flat[255-16*gi -: 16] = words_q[gi];
        end
    endgenerate
    assign cmd_flat[15:0] = 16'h0000;

    assign CMD       = cmd_flat;
    assign VRAM_RD   = rd_active;
    assign VRAM_A    = rd_active ? {t_q[15:2], idx_q} : 18'h0;
    assign CMD_VALID = (state_q == S_DISPATCH);
    assign COPR      = t_q;
    assign LOPR      = lopr_q;
    assign CEF       = cef_q;
    assign BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule

// File: tb/tb_vdp1_cmd_fetch.sv
// Bench for vdp1_cmd_fetch: VRAM/arbiter and draw-engine models, a table-walking
// reference model, directed jump-mode cases and randomized command lists.
module tb_vdp1_cmd_fetch;
    import vdp1_cmd_fetch_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [17:0] VRAM_A;
    logic        VRAM_RD;
    logic [15:0] VRAM_D = 16'h0;
    logic        VRAM_RDY = 1'b0;
    CMDTBL_t     CMD;
    logic        CMD_VALID;
    logic        CMD_ACK = 1'b0;
    logic [15:0] COPR, LOPR;
    logic        CEF, BUSY;

    vdp1_cmd_fetch dut (
        .CLK(CLK), .RST(RST), .START(START),
        .VRAM_A(VRAM_A), .VRAM_RD(VRAM_RD), .VRAM_D(VRAM_D), .VRAM_RDY(VRAM_RDY),
        .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_ACK(CMD_ACK),
        .COPR(COPR), .LOPR(LOPR), .CEF(CEF), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] mem [int];
    int  rdy_delay = 0, ack_delay = 0, arb_wcnt = 0, ack_cnt = 0;
    bit  ack_hold = 0, noise = 0;

    int           rd_log[$];
    logic [255:0] disp_cmd[$];
    logic [15:0]  disp_t[$];
    int           proto_bad = 0;

    int           exp_rd[$];
    logic [255:0] exp_cmd[$];
    logic [15:0]  exp_t[$];
    logic [15:0]  exp_copr;
    logic [15:0]  model_lopr = 16'h0;
    bit           model_ok;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] vram(input int a);
        return mem.exists(a) ? mem[a] : 16'h0000;
    endfunction

    function automatic int waddr(input logic [15:0] t, input int i);
        return int'(t / 16'd4) * 16 + i;
    endfunction

    function automatic logic [15:0] tb_mask(input int i);
        case (i)
            0: return 16'hFF3F;
            1: return 16'hFFFC;
            2: return 16'h9FFF;
            5: return 16'h3FFF;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic bit comm_valid(input logic [3:0] c);
        return c inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
    endfunction

    // VRAM arbiter: answers after rdy_delay cycles, never on two consecutive cycles.
    initial begin
        forever begin
            @(posedge CLK); #1;
            if (VRAM_RDY) begin
                VRAM_RDY = 1'b0; VRAM_D = 16'($urandom); arb_wcnt = 0;
            end else if (VRAM_RD) begin
                if (arb_wcnt >= rdy_delay) begin
                    VRAM_RDY = 1'b1; VRAM_D = vram(int'(VRAM_A));
                end else arb_wcnt++;
            end else begin
                arb_wcnt = 0;
                VRAM_RDY = noise && ($urandom_range(0, 3) == 0);
                VRAM_D   = 16'($urandom);
            end
        end
    end

    initial begin
        forever begin
            @(posedge CLK); #1;
            if (ack_hold) CMD_ACK = 1'b1;
            else if (CMD_VALID) begin
                if (ack_cnt >= ack_delay) CMD_ACK = 1'b1;
                else ack_cnt++;
            end else begin
                CMD_ACK = 1'b0; ack_cnt = 0;
            end
        end
    end

    // Transaction log plus cycle-level handshake rules, tallied into proto_bad.
    initial begin
        bit p_rst, p_rd, p_rdy, p_valid, p_ack, p_w14, p_acc, p2_acc, p_busy;
        logic [17:0]  p_a;
        logic [255:0] p_cmd;
        p_rst = 1; p_rd = 0; p_rdy = 0; p_valid = 0; p_ack = 0; p_w14 = 0;
        p_acc = 0; p2_acc = 0; p_busy = 0; p_a = '0; p_cmd = '0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (VRAM_RD && VRAM_RDY) rd_log.push_back(int'(VRAM_A));
                if (CMD_VALID && CMD_ACK) begin
                    disp_cmd.push_back(CMD); disp_t.push_back(COPR);
                end
                if (!p_rst) begin
                    if (p_rd && !p_rdy && (!VRAM_RD || VRAM_A != p_a)) proto_bad++;
                    if (p_valid && !p_ack && (!CMD_VALID || CMD != p_cmd)) proto_bad++;
                    if (CMD_VALID && VRAM_RD) proto_bad++;
                    if ((CMD_VALID && !p_valid) != p_w14) proto_bad++;
                    if (p_acc && VRAM_RD) proto_bad++;
                    if (p2_acc && !(VRAM_RD && VRAM_A[3:0] == 4'd0)) proto_bad++;
                    if (p_busy && !BUSY && !(CEF && p_rd && p_rdy)) proto_bad++;
                end
            end
            p_rst = RST; p_rd = VRAM_RD; p_rdy = VRAM_RDY; p_a = VRAM_A;
            p_valid = CMD_VALID; p_ack = CMD_ACK; p_cmd = CMD;
            p_w14 = VRAM_RD && VRAM_RDY && VRAM_A[3:0] == 4'd14;
            p2_acc = p_acc; p_acc = CMD_VALID && CMD_ACK; p_busy = BUSY;
        end
    end

    // Reference: walk the list in VRAM table by table.
    task automatic model();
        logic [15:0] t, r, w0, link, v, lopr;
        logic [255:0] c;
        bit pend;
        exp_rd.delete(); exp_cmd.delete(); exp_t.delete();
        model_ok = 0; t = 0; r = 0; pend = 0; lopr = model_lopr; link = 0;
        for (int n = 0; n < 60; n++) begin
            w0 = vram(waddr(t, 0)) & 16'hFF3F;
            exp_rd.push_back(waddr(t, 0));
            if (w0[15] || !comm_valid(w0[3:0])) begin model_ok = 1; break; end
            if (w0[14]) begin
                exp_rd.push_back(waddr(t, 1));
                link = vram(waddr(t, 1)) & 16'hFFFC;
            end else begin
                c = '0; c[255 -: 16] = w0;
                for (int i = 1; i < 15; i++) begin
                    exp_rd.push_back(waddr(t, i));
                    v = vram(waddr(t, i)) & tb_mask(i);
                    c[255-16*i -: 16] = v;
                end
                link = c[239 -: 16];
                exp_cmd.push_back(c); exp_t.push_back(t); lopr = t;
            end
            case (w0[13:12])
                2'd0: t = t + 16'd4;
                2'd1: t = link;
                2'd2: begin
                    if (!pend) begin r = t + 16'd4; pend = 1; end
                    t = link;
                end
                default: if (pend) begin t = r; pend = 0; end else t = t + 16'd4;
            endcase
        end
        exp_copr = t;
        if (model_ok) model_lopr = lopr;
    endtask

    task automatic gen_random();
        int n, j;
        logic [15:0] w0;
        int vc[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        mem.delete();
        n = $urandom_range(3, 9);
        for (int k = 0; k < n; k++) begin
            w0 = 16'($urandom);
            w0[15] = 1'b0;
            w0[14] = ($urandom_range(0, 3) == 0);
            w0[3:0] = ($urandom_range(0, 15) == 0) ? 4'h3 : 4'(vc[$urandom_range(0, 8)]);
            j = $urandom_range(k + 1, n);
            mem[16*k] = w0;
            mem[16*k+1] = 16'(j * 4 + $urandom_range(0, 3));
            for (int i = 2; i < 16; i++) mem[16*k+i] = 16'($urandom);
        end
        mem[16*n] = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
    endtask

    task automatic gen_valid_list();
        int tries = 0;
        do begin gen_random(); model(); tries++; end while (!model_ok && tries < 20);
        chk("gen_terminating", model_ok, 1'b1);
    endtask

    task automatic start_run();
        rd_log.delete(); disp_cmd.delete(); disp_t.delete(); proto_bad = 0;
        @(negedge CLK); START = 1'b1;
        @(negedge CLK); START = 1'b0;
        chk("start_state", {VRAM_RD, VRAM_A, BUSY, CEF}, {1'b1, 18'h0, 1'b1, 1'b0});
    endtask

    task automatic wait_done(input int poke);
        int n = 0;
        while (!(CEF && !BUSY) && n < 20000) begin
            START = (poke > 0 && n == poke && BUSY);
            @(negedge CLK); n++;
        end
        START = 1'b0;
        chk("done_in_time", n < 20000, 1'b1);
    endtask

    task automatic compare_run(input string nm);
        chk({nm, ".nreads"}, rd_log.size(), exp_rd.size());
        for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
            chk($sformatf("%s.rd%0d", nm, i), rd_log[i], exp_rd[i]);
        chk({nm, ".ncmd"}, disp_cmd.size(), exp_cmd.size());
        for (int i = 0; i < disp_cmd.size() && i < exp_cmd.size(); i++) begin
            chk($sformatf("%s.cmd%0d", nm, i), disp_cmd[i], exp_cmd[i]);
            chk($sformatf("%s.cmdT%0d", nm, i), disp_t[i], exp_t[i]);
        end
        chk({nm, ".copr"}, COPR, exp_copr);
        chk({nm, ".lopr"}, LOPR, model_lopr);
        chk({nm, ".cef_busy"}, {CEF, BUSY}, 2'b10);
        chk({nm, ".protocol"}, proto_bad, 0);
        $display("run %s: %0d reads, %0d commands, COPR=%04h LOPR=%04h",
                 nm, rd_log.size(), disp_cmd.size(), COPR, LOPR);
    endtask

    task automatic load_basic();
        mem.delete();
        mem[0] = 16'h0000; mem[1] = 16'hFFFF; mem[2] = 16'hFFFF;
        for (int i = 3; i < 16; i++) mem[i] = 16'h1234;
        mem[16'h10] = 16'h8000;
    endtask

    initial begin
        CMDTBL_t cc;
        int w0_seq[$];
        int n;

        repeat (3) @(negedge CLK);
        chk("reset.ctl", {VRAM_RD, VRAM_A, CMD_VALID, COPR, LOPR, CEF, BUSY}, '0);
        chk("reset.cmd", CMD, '0);
        RST = 1'b0;

        // Basic table then END, ACK held high; START in the DONE cycle is ignored.
        load_basic(); ack_hold = 1; model();
        start_run(); wait_done(0);
        START = 1'b1; @(negedge CLK); START = 1'b0;
        chk("t1.start_in_done", {BUSY, VRAM_RD}, 2'b00);
        chk("t1.nreads", rd_log.size(), 16);
        if (rd_log.size() == 16) chk("t1.last_rd", rd_log[15], 32'h10);
        chk("t1.ncmd", disp_cmd.size(), 1);
        if (disp_cmd.size() > 0) begin
            cc = disp_cmd[0];
            chk("t1.link", cc.CMDLINK, 16'hFFFC);
            chk("t1.pmod", cc.CMDPMOD, 16'h9FFF);
            chk("t1.unused", cc.UNUSED, 16'h0);
        end
        chk("t1.copr", COPR, 16'h0004);
        chk("t1.lopr", LOPR, 16'h0000);
        compare_run("t1");
        ack_hold = 0;

        // Assign to 0x0100.
        mem.delete(); mem[0] = 16'h1000; mem[1] = 16'h0100; mem[16'h400] = 16'h8000;
        model(); start_run(); wait_done(0);
        if (rd_log.size() > 15) chk("t2.after_ack_rd", rd_log[15], 32'h400);
        chk("t2.copr", COPR, 16'h0100);
        compare_run("t2");

        // Call 0x40, nested call 0x80 (acts as assign), return lands on 0x0004.
        mem.delete();
        mem[0] = 16'h2000; mem[1] = 16'h0040;
        mem[16'h100] = 16'h2000; mem[16'h101] = 16'h0080;
        mem[16'h200] = 16'h3000;
        mem[16'h010] = 16'h8000;
        model(); start_run(); wait_done(0);
        w0_seq.delete();
        foreach (rd_log[i]) if (rd_log[i] % 16 == 0) w0_seq.push_back(rd_log[i]);
        chk("t3.nw0", w0_seq.size(), 4);
        if (w0_seq.size() == 4)
            chk("t3.w0_order", {w0_seq[0][17:0], w0_seq[1][17:0], w0_seq[2][17:0], w0_seq[3][17:0]},
                {18'h000, 18'h100, 18'h200, 18'h010});
        chk("t3.lopr", LOPR, 16'h0080);
        compare_run("t3");

        // Skipped table.
        mem.delete(); mem[0] = 16'h4000; mem[1] = 16'h1234; mem[16'h10] = 16'h8000;
        model(); start_run(); wait_done(0);
        chk("t4.nreads", rd_log.size(), 3);
        if (rd_log.size() == 3) chk("t4.addrs", {rd_log[0][17:0], rd_log[1][17:0], rd_log[2][17:0]},
                                    {18'h00, 18'h01, 18'h10});
        chk("t4.ncmd", disp_cmd.size(), 0);
        compare_run("t4");

        // Invalid COMM terminates at table 0.
        mem.delete(); mem[0] = 16'h0003;
        model(); start_run(); wait_done(0);
        chk("t5.nreads", rd_log.size(), 1);
        chk("t5.ncmd", disp_cmd.size(), 0);
        compare_run("t5");

        // Back-pressure on both sides, START poked while busy.
        rdy_delay = 3; ack_delay = 10; noise = 1;
        gen_valid_list(); start_run(); wait_done(20);
        compare_run("bp");

        for (int it = 0; it < 8; it++) begin
            rdy_delay = $urandom_range(0, 2); ack_delay = $urandom_range(0, 3);
            gen_valid_list(); start_run(); wait_done($urandom_range(5, 60));
            compare_run($sformatf("rnd%0d", it));
        end

        // Reset in the middle of a table body.
        rdy_delay = 1; ack_delay = 0; noise = 0;
        load_basic(); start_run();
        n = 0;
        while (!(VRAM_RD && VRAM_A[3:0] == 4'd5) && n < 200) begin @(negedge CLK); n++; end
        chk("rst.reached_body", n < 200, 1'b1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst.ctl", {VRAM_RD, VRAM_A, CMD_VALID, COPR, LOPR, CEF, BUSY}, '0);
        chk("rst.cmd", CMD, '0);
        @(negedge CLK);
        chk("rst.no_rd", VRAM_RD, 1'b0);
        RST = 1'b0; model_lopr = 16'h0;
        @(negedge CLK);
        model(); start_run(); wait_done(0);
        compare_run("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
